// File: rtl/dm_cache_ctrl_pkg.sv
// Shared types and field widths for the direct-mapped L1 cache controller.
// Addresses split as {tag, index, word, byte}; a line is eight 32-bit words.
package dm_cache_ctrl_pkg;

  localparam int NUM_SETS   = 16;
  localparam int INDEX_W    = $clog2(NUM_SETS);
  localparam int OFFSET_W   = 5;
  localparam int LINE_BITS  = 256;
  localparam int LINE_BYTES = LINE_BITS / 8;
  localparam int ADDR_W     = 32;
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORD_SEL_W = 3;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [INDEX_W-1:0]   index_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } cache_state_t;

  function automatic logic [ADDR_W-1:0] line_addr(input tag_t tag, input index_t idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU-side and memory-side buses of the cache controller.
// Handshake: a requester raises read or write with address/data stable and holds them
// until the responder pulses resp for exactly one cycle; that cycle completes the transfer.
interface dm_cache_cpu_if;
  import dm_cache_ctrl_pkg::*;

  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_byte_enable;
  logic [31:0]       cpu_rdata;
  logic              cpu_resp;

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_wdata, cpu_byte_enable,
    input  cpu_rdata, cpu_resp
  );

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_wdata, cpu_byte_enable,
    output cpu_rdata, cpu_resp
  );
endinterface

interface dm_cache_mem_if;
  import dm_cache_ctrl_pkg::*;

  logic [ADDR_W-1:0]     mem_address;
  logic                  mem_read;
  logic                  mem_write;
  line_t                 mem_wdata;
  logic [LINE_BYTES-1:0] mem_byte_enable;
  line_t                 mem_rdata;
  logic                  mem_resp;

  modport master (
    output mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/dm_cache_ctrl_line_array.sv
// Storage for NUM_SETS cache lines: valid/dirty (async reset), tag and data (no reset).
// Combinational read port, single write port with a per-byte data mask.
module cache_line_array
  import dm_cache_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  index_t                rd_idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output tag_t                  rd_tag,
  output line_t                 rd_data,
  input  logic                  wr_en,
  input  index_t                wr_idx,
  input  logic                  wr_valid,
  input  logic                  wr_dirty,
  input  tag_t                  wr_tag,
  input  logic [LINE_BYTES-1:0] wr_mask,
  input  line_t                 wr_data
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  tag_t                tag_q  [NUM_SETS];
  line_t               data_q [NUM_SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Tag is rewritten on every write; callers pass the current tag when it must not change.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      for (int b = 0; b < LINE_BYTES; b++) begin
        if (wr_mask[b]) data_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 cache controller.
// All bus outputs decode from the current state so an async reset drops them at once.
module dm_cache_ctrl
  import dm_cache_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  dm_cache_cpu_if.slave   cpu,
  dm_cache_mem_if.master  mem,
  output cache_state_t    state_dbg
);

  cache_state_t           state_q, state_d;
  tag_t                   req_tag_q;
  index_t                 req_idx_q;
  logic [WORD_SEL_W-1:0]  req_word_q;
  logic                   req_write_q;
  logic [31:0]            req_wdata_q;
  logic [3:0]             req_be_q;

  logic                   rd_valid, rd_dirty;
  tag_t                   rd_tag;
  line_t                  rd_data;
  logic                   wr_en, wr_valid, wr_dirty;
  tag_t                   wr_tag;
  logic [LINE_BYTES-1:0]  wr_mask;
  line_t                  wr_data;

  logic                   hit;
  logic [31:0]            rd_word;
  logic                   cpu_resp_d;
  logic [31:0]            cpu_rdata_d;
  logic                   mem_read_d, mem_write_d;
  logic [ADDR_W-1:0]      mem_address_d;
  line_t                  mem_wdata_d;

  cache_line_array u_lines (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (req_idx_q),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (req_idx_q),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_mask  (wr_mask),
    .wr_data  (wr_data)
  );

  // Write wins when the CPU raises both read and write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_word_q  <= '0;
      req_write_q <= 1'b0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (cpu.cpu_read || cpu.cpu_write)) begin
        req_tag_q   <= cpu.cpu_address[ADDR_W-1 -: TAG_W];
        req_idx_q   <= cpu.cpu_address[OFFSET_W +: INDEX_W];
        req_word_q  <= cpu.cpu_address[2 +: WORD_SEL_W];
        req_write_q <= cpu.cpu_write;
        req_wdata_q <= cpu.cpu_wdata;
        req_be_q    <= cpu.cpu_byte_enable;
      end
    end
  end

  assign hit     = rd_valid && (rd_tag == req_tag_q);
  assign rd_word = rd_data[req_word_q*32 +: 32];

  always_comb begin
    state_d       = state_q;
    cpu_resp_d    = 1'b0;
    cpu_rdata_d   = '0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_address_d = '0;
    mem_wdata_d   = '0;
    wr_en         = 1'b0;
    wr_valid      = rd_valid;
    wr_dirty      = rd_dirty;
    wr_tag        = rd_tag;
    wr_mask       = '0;
    wr_data       = {(LINE_BITS/32){req_wdata_q}};
    case (state_q)
      IDLE: begin
        if (cpu.cpu_read || cpu.cpu_write) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_resp_d = 1'b1;
          state_d    = IDLE;
          if (req_write_q) begin
            // A zero byte enable still marks the line dirty with no data change.
            wr_en    = 1'b1;
            wr_valid = 1'b1;
            wr_dirty = 1'b1;
            wr_mask  = LINE_BYTES'(req_be_q) << {req_word_q, 2'b00};
          end else begin
            cpu_rdata_d = rd_word;
          end
        end else if (rd_valid && rd_dirty) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_write_d   = 1'b1;
        mem_address_d = line_addr(rd_tag, req_idx_q);
        mem_wdata_d   = rd_data;
        if (mem.mem_resp) begin
          wr_en    = 1'b1;
          wr_dirty = 1'b0;
          state_d  = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_read_d    = 1'b1;
        mem_address_d = line_addr(req_tag_q, req_idx_q);
        if (mem.mem_resp) begin
          wr_en    = 1'b1;
          wr_valid = 1'b1;
          wr_dirty = 1'b0;
          wr_tag   = req_tag_q;
          wr_mask  = '1;
          wr_data  = mem.mem_rdata;
          state_d  = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu.cpu_resp        = cpu_resp_d;
  assign cpu.cpu_rdata       = cpu_rdata_d;
  assign mem.mem_read        = mem_read_d;
  assign mem.mem_write       = mem_write_d;
  assign mem.mem_address     = mem_address_d;
  assign mem.mem_wdata       = mem_wdata_d;
  assign mem.mem_byte_enable = '1;
  assign state_dbg           = state_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: flat-memory reference model, residency model for traffic
// prediction, CPU scoreboard queue checked by a monitor, and a line-memory adaptor model.
module tb_dm_cache_ctrl;
  import dm_cache_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dm_cache_cpu_if cif();
  dm_cache_mem_if mif();
  cache_state_t   state_dbg;

  logic adp_resp      = 1'b0;
  logic spurious_resp = 1'b0;
  logic adaptor_stall = 1'b0;
  assign mif.mem_resp = adp_resp | spurious_resp;

  dm_cache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (cif),
    .mem       (mif),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];      // {check_data, rdata}
  logic [32:0] mem_exp_q[$];  // {is_write, line address}

  logic [31:0] ref_mem  [logic [29:0]];  // CPU-visible memory
  logic [31:0] back_mem [logic [29:0]];  // contents held behind the cache

  // Residency model: which line each set holds and whether it has unwritten data.
  logic        m_valid [NUM_SETS];
  logic [22:0] m_tag   [NUM_SETS];
  logic        m_dirty [NUM_SETS];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return {wa[13:0], 2'b10, ~wa[15:0]} ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] back_rd(input logic [29:0] wa);
    return back_mem.exists(wa) ? back_mem[wa] : init_word(wa);
  endfunction

  function automatic line_t ref_line(input logic [31:0] la);
    line_t l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_rd({la[31:5], 3'(w)});
    return l;
  endfunction

  function automatic line_t back_line(input logic [31:0] la);
    line_t l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = back_rd({la[31:5], 3'(w)});
    return l;
  endfunction

  task automatic poke(input logic [31:0] addr, input logic [31:0] val);
    ref_mem[addr[31:2]]  = val;
    back_mem[addr[31:2]] = val;
  endtask

  task automatic model_reset();
    for (int s = 0; s < NUM_SETS; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
      m_tag[s]   = '0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic wr, input logic both, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    logic [3:0]  idx;
    logic [22:0] tag;
    logic        hit;
    logic        got;
    logic [31:0] old, nw;
    int          cycles;
    idx = addr[8:5];
    tag = addr[31:9];
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) mem_exp_q.push_back({1'b1, m_tag[idx], idx, 5'b0});
      mem_exp_q.push_back({1'b0, tag, idx, 5'b0});
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      m_dirty[idx] = 1'b1;
      old = ref_rd(addr[31:2]);
      for (int b = 0; b < 4; b++) nw[b*8 +: 8] = be[b] ? wdata[b*8 +: 8] : old[b*8 +: 8];
      ref_mem[addr[31:2]] = nw;
      exp_q.push_back({1'b0, 32'h0});
    end else begin
      exp_q.push_back({1'b1, ref_rd(addr[31:2])});
    end

    @(posedge clk); #1;
    cif.cpu_address     = addr;
    cif.cpu_write       = wr;
    cif.cpu_read        = !wr || both;
    cif.cpu_wdata       = wdata;
    cif.cpu_byte_enable = be;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 500) begin
      @(negedge clk);
      cycles++;
      if (cif.cpu_resp) got = 1'b1;
    end
    check("cpu_resp_seen", got, 1'b1);
    if (hit) check("hit_latency", cycles, 2);
    @(posedge clk); #1;
    cif.cpu_read  = 1'b0;
    cif.cpu_write = 1'b0;
    check("mem_traffic_done", mem_exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  logic [32:0] mon_e;
  always @(negedge clk) begin
    if (rst && cif.cpu_resp) begin
      if (exp_q.size() == 0) begin
        check("cpu_resp_unexpected", cif.cpu_resp, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[32]) check("cpu_rdata", cif.cpu_rdata, mon_e[31:0]);
      end
    end
  end

  // ---------------- memory adaptor model ----------------
  initial begin : adaptor
    logic        op_w;
    logic [31:0] a;
    line_t       wd;
    logic [32:0] me;
    logic        aborted;
    int          n, wait_n;
    mif.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && (mif.mem_read || mif.mem_write)) begin
        check("mem_rd_wr_exclusive", mif.mem_read & mif.mem_write, 1'b0);
        check("mem_byte_enable", mif.mem_byte_enable, 32'hFFFF_FFFF);
        op_w = mif.mem_write;
        a    = mif.mem_address;
        wd   = mif.mem_wdata;
        if (mem_exp_q.size() == 0) begin
          check("mem_unexpected", {op_w, a}, 33'h0);
        end else begin
          me = mem_exp_q.pop_front();
          check("mem_op_addr", {op_w, a}, me);
        end
        if (op_w) check("writeback_line", wd, ref_line(a));
        wait_n  = $urandom_range(0, 2);
        n       = 0;
        aborted = 1'b0;
        while ((n < wait_n || adaptor_stall) && !aborted && n < 1000) begin
          @(negedge clk);
          n++;
          if (!rst || !(mif.mem_read || mif.mem_write)) aborted = 1'b1;
        end
        if (!aborted) begin
          if (op_w) begin
            for (int w = 0; w < 8; w++) back_mem[{a[31:5], 3'(w)}] = wd[w*32 +: 32];
          end else begin
            mif.mem_rdata = back_line(a);
          end
          adp_resp = 1'b1;
          @(negedge clk);
          adp_resp = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int          n;
    logic        seen;
    logic [31:0] addr;
    cif.cpu_address     = '0;
    cif.cpu_read        = 1'b0;
    cif.cpu_write       = 1'b0;
    cif.cpu_wdata       = '0;
    cif.cpu_byte_enable = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_cpu_resp",    cif.cpu_resp, 1'b0);
    check("rst_cpu_rdata",   cif.cpu_rdata, 32'h0);
    check("rst_mem_read",    mif.mem_read, 1'b0);
    check("rst_mem_write",   mif.mem_write, 1'b0);
    check("rst_mem_address", mif.mem_address, 32'h0);
    check("rst_mem_wdata",   mif.mem_wdata, 256'h0);
    check("rst_state",       state_dbg, IDLE);
    @(posedge clk); #1 rst = 1'b1;

    // Cold miss, then hit, then partial write, then read back the merge.
    poke(32'h0000_0104, 32'hDEAD_BEEF);
    do_req(1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
    do_req(1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
    do_req(1'b1, 1'b0, 32'h0000_0104, 32'h1234_5678, 4'b0011);
    do_req(1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
    check("merged_word_model", ref_rd(30'h41), 32'hDEAD_5678);
    // Conflict on a dirty line: writeback of 0x100, then refill of 0x2100.
    do_req(1'b0, 1'b0, 32'h0000_2104, 32'h0, 4'h0);

    // Stray adaptor response while idle must be ignored.
    @(posedge clk); #1 spurious_resp = 1'b1;
    @(posedge clk); #1 spurious_resp = 1'b0;
    @(negedge clk);
    check("spurious_state", state_dbg, IDLE);
    check("spurious_mem_read", mif.mem_read, 1'b0);

    // Reset in the middle of a refill.
    adaptor_stall = 1'b1;
    mem_exp_q.push_back({1'b0, 32'h0000_0100});
    @(posedge clk); #1;
    cif.cpu_address = 32'h0000_0104;
    cif.cpu_read    = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (mif.mem_read) seen = 1'b1;
    end
    check("abort_mem_read_seen", seen, 1'b1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("abort_mem_read", mif.mem_read, 1'b0);
    check("abort_state", state_dbg, IDLE);
    check("abort_cpu_resp", cif.cpu_resp, 1'b0);
    cif.cpu_read  = 1'b0;
    adaptor_stall = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("abort_mem_q_empty", mem_exp_q.size(), 0);
    do_req(1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0);

    // Read and write raised together behave as a write.
    do_req(1'b1, 1'b1, 32'h0000_2108, 32'hCAFE_F00D, 4'hF);
    do_req(1'b0, 1'b0, 32'h0000_2108, 32'h0, 4'h0);
    check("both_rdwr_model", ref_rd(30'h842), 32'hCAFE_F00D);

    // Random traffic over four tags per set to mix hits, clean and dirty misses.
    for (int i = 0; i < 300; i++) begin
      addr = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5)
           | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 9) < 4)
        do_req(1'b1, 1'b0, addr, $urandom, 4'($urandom_range(0, 15)));
      else
        do_req(1'b0, 1'b0, addr, 32'h0, 4'h0);
    end

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
